// File: rtl/win33_out_trans.sv
// Winograd F(2x2,3x3) output transform: Y = A^T*M*A, accumulated over CH_NUM channel tiles.
// Optional build macro WIN_OUT_RELU_EN clamps negative outputs to zero after saturation.
module win33_out_trans #(
    parameter int CH_NUM = 4,
    parameter int ACC_W  = 40,
    parameter int OUT_W  = 32,
    localparam int CNT_W = $clog2(CH_NUM + 1)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 clear,
    input  logic                 in_valid,
    input  logic [127:0]         m_row1,
    input  logic [127:0]         m_row2,
    input  logic [127:0]         m_row3,
    input  logic [127:0]         m_row4,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [4*OUT_W-1:0]   y_tile,
    output logic [CNT_W-1:0]     ch_cnt,
    output logic                 overflow
);

    localparam int M_W = 32;
    localparam int T_W = 34;
    localparam int Y_W = 36;

    localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] SAT_MIN = {{(ACC_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};
    localparam logic [CNT_W-1:0]        LAST_CNT = CNT_W'(CH_NUM - 1);

    function automatic logic [OUT_W-1:0] sat_elem(input logic signed [ACC_W-1:0] v);
        logic [OUT_W-1:0] r;
        if (v > SAT_MAX) begin
            r = SAT_MAX[OUT_W-1:0];
        end else if (v < SAT_MIN) begin
            r = SAT_MIN[OUT_W-1:0];
        end else begin
            r = v[OUT_W-1:0];
        end
`ifdef WIN_OUT_RELU_EN
        if (r[OUT_W-1]) begin
            r = '0;
        end
`endif
        return r;
    endfunction

    // ------------------------------------------------------------------
    // Input unpack: m[r][c], column 0 sits in the top 32 bits of each row
    // ------------------------------------------------------------------
    logic [127:0]            rows [4];
    logic signed [M_W-1:0]   m    [4][4];

    always_comb begin
        rows[0] = m_row1;
        rows[1] = m_row2;
        rows[2] = m_row3;
        rows[3] = m_row4;
        for (int unsigned r = 0; r < 4; r++) begin
            for (int unsigned c = 0; c < 4; c++) begin
                m[r][c] = rows[r][(3-c)*M_W +: M_W];
            end
        end
    end

    // ------------------------------------------------------------------
    // S1: T = A^T * M (2x4)
    // ------------------------------------------------------------------
    logic signed [T_W-1:0] t_d [2][4];
    logic signed [T_W-1:0] t_q [2][4];
    logic                  s1_valid;

    always_comb begin
        for (int unsigned c = 0; c < 4; c++) begin
            t_d[0][c] = T_W'(m[0][c]) + T_W'(m[1][c]) + T_W'(m[2][c]);
            t_d[1][c] = T_W'(m[1][c]) - T_W'(m[2][c]) - T_W'(m[3][c]);
        end
    end

    // A tile presented alongside clear is still captured: it is the first tile after the restart.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            t_q      <= '{default: '0};
        end else begin
            s1_valid <= in_valid;
            if (in_valid) begin
                t_q <= t_d;
            end
        end
    end

    // ------------------------------------------------------------------
    // S2: Yt = T * A (2x2), flattened as {y00, y01, y10, y11}
    // ------------------------------------------------------------------
    logic signed [Y_W-1:0] y_d [4];
    logic signed [Y_W-1:0] y_q [4];
    logic                  s2_valid;

    always_comb begin
        for (int unsigned i = 0; i < 2; i++) begin
            y_d[2*i]   = Y_W'(t_q[i][0]) + Y_W'(t_q[i][1]) + Y_W'(t_q[i][2]);
            y_d[2*i+1] = Y_W'(t_q[i][1]) - Y_W'(t_q[i][2]) - Y_W'(t_q[i][3]);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid <= 1'b0;
            y_q      <= '{default: '0};
        end else begin
            s2_valid <= s1_valid && !clear;
            if (s1_valid) begin
                y_q <= y_d;
            end
        end
    end

    // ------------------------------------------------------------------
    // S3: channel accumulation and output register
    // ------------------------------------------------------------------
    logic signed [ACC_W-1:0] acc     [4];
    logic signed [ACC_W-1:0] sum     [4];
    logic [4*OUT_W-1:0]      tile_d;
    logic                    last_tile;
    logic                    complete;
    logic                    load_ok;

    always_comb begin
        tile_d = '0;
        for (int unsigned e = 0; e < 4; e++) begin
            sum[e] = ((ch_cnt == '0) ? '0 : acc[e]) + ACC_W'(y_q[e]);
            tile_d[(3-e)*OUT_W +: OUT_W] = sat_elem(sum[e]);
        end
    end

    assign last_tile = (ch_cnt == LAST_CNT);
    assign complete  = s2_valid && !clear && last_tile;
    assign load_ok   = !out_valid || out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc    <= '{default: '0};
            ch_cnt <= '0;
        end else if (clear) begin
            acc    <= '{default: '0};
            ch_cnt <= '0;
        end else if (s2_valid) begin
            if (last_tile) begin
                acc    <= '{default: '0};
                ch_cnt <= '0;
            end else begin
                acc    <= sum;
                ch_cnt <= ch_cnt + 1'b1;
            end
        end
    end

    // A completion in the accept cycle replaces the departing tile without a gap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            y_tile    <= '0;
            overflow  <= 1'b0;
        end else begin
            if (complete && load_ok) begin
                out_valid <= 1'b1;
                y_tile    <= tile_d;
            end else begin
                if (out_valid && out_ready) begin
                    out_valid <= 1'b0;
                end
                if (complete) begin
                    overflow <= 1'b1;
                end
            end
        end
    end

endmodule
